// File: rtl/pim_conv_line_acc.sv
// rtl/pim_conv_line_acc.sv - multi-slice PIM convolution line with streamed features and saturating row accumulator
//
// Purpose: weight rows (SIZE bits) live in NSLICE = SIZE/SLICE per-slice row
// memories. Every accepted feature beat is matched against one weight row,
// popcount-reduced per slice, summed across slices and accumulated over
// n_rows consecutive rows (addresses wrap modulo DEPTH). The final sum is
// presented on a valid/ready result port.
//
// Optional feature macro: PIM_SIGNED_EN
//   undefined: partial = popcount(feature & row), unsigned saturating accumulator
//   defined  : partial = 2*popcount(~(feature ^ row)) - SLICE, two's-complement
//              saturating accumulator
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data    weight row write, honoured only in IDLE
//   start/base_addr/n_rows   sweep launch, honoured only in IDLE
//   in_valid/in_ready        feature beat handshake, input_feature payload
//   busy                     high in RUN, DRAIN and DONE
//   out_valid/out_ready      result handshake, conv_value payload
module pim_conv_line_acc #(
   parameter  int SIZE  = 256,
   parameter  int SLICE = 128,
   parameter  int DEPTH = 32,
   parameter  int OUT_W = 16,
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [SIZE-1:0]  wr_data,
   input  logic             start,
   input  logic [AW-1:0]    base_addr,
   input  logic [AW-1:0]    n_rows,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [SIZE-1:0]  input_feature,
   output logic             busy,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] conv_value
);

   localparam int NSLICE = SIZE / SLICE;
   localparam int CW     = $clog2(SLICE + 1);
`ifdef PIM_SIGNED_EN
   localparam int PW     = CW + 1;
`else
   localparam int PW     = CW;
`endif
   localparam int SW     = $clog2(SIZE + 1) + 1;
   // Headroom so accumulator + one full beat never overflows before clamping.
   localparam int EW     = OUT_W + SW + 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t state_q, state_d;

   logic [SLICE-1:0] mem_q [NSLICE][DEPTH];

   logic [AW-1:0]    addr_q;
   logic [AW-1:0]    rem_q;
   logic [OUT_W-1:0] acc_q;

   logic             v0_q, v1_q, v2_q;
   logic             last0_q, last1_q, last2_q;
   logic [SIZE-1:0]  feat0_q, feat1_q;
   logic [AW-1:0]    addr0_q;
   logic [SLICE-1:0] row_q  [NSLICE];
   logic [PW-1:0]    part_q [NSLICE];
   logic [PW-1:0]    part_d [NSLICE];

   logic             beat_acc;
   logic             start_acc;
   logic             last_beat;
   logic [AW-1:0]    addr_next;
   logic [OUT_W-1:0] acc_d;

   function automatic logic [AW-1:0] wrap_addr(input logic [AW-1:0] a);
      // AW = clog2(DEPTH) keeps any AW-bit value below 2*DEPTH, so one subtract suffices.
      if (int'(a) >= DEPTH) return a - AW'(DEPTH);
      return a;
   endfunction

   function automatic logic [CW-1:0] popcnt(input logic [SLICE-1:0] v);
      logic [CW-1:0] c;
      c = '0;
      for (int i = 0; i < SLICE; i++) c = c + CW'(v[i]);
      return c;
   endfunction

   assign in_ready   = (state_q == RUN);
   assign busy       = (state_q != IDLE);
   assign out_valid  = (state_q == DONE);
   assign conv_value = acc_q;

   assign beat_acc  = in_ready && in_valid;
   assign start_acc = (state_q == IDLE) && start;
   assign last_beat = (rem_q == AW'(1));
   assign addr_next = (int'(addr_q) == DEPTH - 1) ? '0 : addr_q + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = (n_rows == '0) ? DONE : RUN;
         RUN:     if (beat_acc && last_beat) state_d = DRAIN;
         // The last beat's partials are added on this same edge.
         DRAIN:   if (v2_q && last2_q) state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Row memories and pipeline payload carry no reset; weights survive rst.
   always_ff @(posedge clk) begin
      if (wr_en && state_q == IDLE) begin
         for (int s = 0; s < NSLICE; s++)
            mem_q[s][wrap_addr(wr_addr)] <= wr_data[s*SLICE +: SLICE];
      end
      if (beat_acc) begin
         feat0_q <= input_feature;
         addr0_q <= addr_q;
      end
      feat1_q <= feat0_q;
      for (int s = 0; s < NSLICE; s++) begin
         row_q[s]  <= mem_q[s][addr0_q];
         part_q[s] <= part_d[s];
      end
   end

   always_comb begin
      for (int s = 0; s < NSLICE; s++) begin
`ifdef PIM_SIGNED_EN
         part_d[s] = {popcnt(~(feat1_q[s*SLICE +: SLICE] ^ row_q[s])), 1'b0} - PW'(SLICE);
`else
         part_d[s] = popcnt(feat1_q[s*SLICE +: SLICE] & row_q[s]);
`endif
      end
   end

   // Cross-slice sum plus accumulator, clamped to the representable range.
   always_comb begin
      logic signed [EW-1:0] sum_x, acc_x, lim_hi;
`ifdef PIM_SIGNED_EN
      logic signed [EW-1:0] lim_lo;
      lim_lo = '1;
      lim_lo[OUT_W-1:0] = {1'b1, {(OUT_W-1){1'b0}}};
      lim_hi = '0;
      lim_hi[OUT_W-1:0] = {1'b0, {(OUT_W-1){1'b1}}};
      acc_x  = {{(EW-OUT_W){acc_q[OUT_W-1]}}, acc_q};
      sum_x  = '0;
      for (int s = 0; s < NSLICE; s++)
         sum_x = sum_x + {{(EW-PW){part_q[s][PW-1]}}, part_q[s]};
      acc_x = acc_x + sum_x;
      if (acc_x > lim_hi)      acc_d = lim_hi[OUT_W-1:0];
      else if (acc_x < lim_lo) acc_d = lim_lo[OUT_W-1:0];
      else                     acc_d = acc_x[OUT_W-1:0];
`else
      lim_hi = '0;
      lim_hi[OUT_W-1:0] = '1;
      acc_x  = {{(EW-OUT_W){1'b0}}, acc_q};
      sum_x  = '0;
      for (int s = 0; s < NSLICE; s++)
         sum_x = sum_x + {{(EW-PW){1'b0}}, part_q[s]};
      acc_x = acc_x + sum_x;
      if (acc_x > lim_hi) acc_d = lim_hi[OUT_W-1:0];
      else                acc_d = acc_x[OUT_W-1:0];
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v0_q    <= 1'b0;
         v1_q    <= 1'b0;
         v2_q    <= 1'b0;
         last0_q <= 1'b0;
         last1_q <= 1'b0;
         last2_q <= 1'b0;
         addr_q  <= '0;
         rem_q   <= '0;
         acc_q   <= '0;
      end else begin
         v0_q    <= beat_acc;
         last0_q <= beat_acc && last_beat;
         v1_q    <= v0_q;
         last1_q <= last0_q;
         v2_q    <= v1_q;
         last2_q <= last1_q;
         if (start_acc) begin
            addr_q <= wrap_addr(base_addr);
            rem_q  <= n_rows;
            acc_q  <= '0;
         end else begin
            if (beat_acc) begin
               addr_q <= addr_next;
               rem_q  <= rem_q - 1'b1;
            end
            if (v2_q) acc_q <= acc_d;
         end
      end
   end

endmodule

// File: tb/tb_pim_conv_line_acc.sv
// tb/tb_pim_conv_line_acc.sv - directed scoreboard bench for pim_conv_line_acc
module tb_pim_conv_line_acc;

   localparam int SIZE  = 256;
   localparam int SLICE = 128;
   localparam int DEPTH = 32;
   localparam int AW    = 5;
   localparam int WA    = 16;
   localparam int WB    = 9;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            wr_en = 1'b0;
   logic [AW-1:0]   wr_addr = '0;
   logic [SIZE-1:0] wr_data = '0;
   logic            start = 1'b0;
   logic [AW-1:0]   base_addr = '0;
   logic [AW-1:0]   n_rows = '0;
   logic            in_valid = 1'b0;
   logic [SIZE-1:0] input_feature = '0;
   logic            out_ready = 1'b0;

   logic            in_ready_a, busy_a, out_valid_a;
   logic [WA-1:0]   conv_a;
   logic            in_ready_b, busy_b, out_valid_b;
   logic [WB-1:0]   conv_b;

   int total = 0;
   int bad   = 0;

   logic [SIZE-1:0] wmem [DEPTH];
   logic [SIZE-1:0] fq [$];
   int              sb_a [$];
   int              sb_b [$];

   always #5 clk = ~clk;

   pim_conv_line_acc #(.SIZE(SIZE), .SLICE(SLICE), .DEPTH(DEPTH), .OUT_W(WA)) dut_a (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .start(start), .base_addr(base_addr), .n_rows(n_rows),
      .in_valid(in_valid), .in_ready(in_ready_a), .input_feature(input_feature),
      .busy(busy_a), .out_valid(out_valid_a), .out_ready(out_ready), .conv_value(conv_a));

   pim_conv_line_acc #(.SIZE(SIZE), .SLICE(SLICE), .DEPTH(DEPTH), .OUT_W(WB)) dut_b (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .start(start), .base_addr(base_addr), .n_rows(n_rows),
      .in_valid(in_valid), .in_ready(in_ready_b), .input_feature(input_feature),
      .busy(busy_b), .out_valid(out_valid_b), .out_ready(out_ready), .conv_value(conv_b));

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [SIZE-1:0] rnd_vec();
      logic [SIZE-1:0] v;
      for (int i = 0; i < SIZE / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   function automatic int beat_sum(input logic [SIZE-1:0] f, input logic [SIZE-1:0] r);
`ifdef PIM_SIGNED_EN
      return 2 * $countones(~(f ^ r)) - SIZE;
`else
      return $countones(f & r);
`endif
   endfunction

   function automatic int sat(input int v, input int w);
      int hi, lo;
`ifdef PIM_SIGNED_EN
      hi = (1 << (w - 1)) - 1;
      lo = -(1 << (w - 1));
`else
      hi = (1 << w) - 1;
      lo = 0;
`endif
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   function automatic int bits(input int v, input int w);
      return v & ((1 << w) - 1);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_row(input int a, input logic [SIZE-1:0] d);
      wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
      tick();
      wr_en = 1'b0;
      wmem[a] = d;
   endtask

   // Runs one sweep over fq; disturb pokes a write and a start into RUN,
   // wws writes row base in the same cycle as start.
   task automatic sweep(input string nm, input int base, input int n, input bit gaps,
                        input int hold, input bit disturb, input bit wws,
                        input logic [SIZE-1:0] wdat);
      int ea, eb, k, cyc, lat, xa, xb;
      if (wws) wmem[base % DEPTH] = wdat;
      ea = 0; eb = 0;
      for (int i = 0; i < n; i++) begin
         int s;
         s  = beat_sum(fq[i], wmem[(base + i) % DEPTH]);
         ea = sat(ea + s, WA);
         eb = sat(eb + s, WB);
      end
      sb_a.push_back(bits(ea, WA));
      sb_b.push_back(bits(eb, WB));

      start = 1'b1; base_addr = AW'(base); n_rows = AW'(n);
      if (wws) begin wr_en = 1'b1; wr_addr = AW'(base); wr_data = wdat; end
      tick();
      start = 1'b0; wr_en = 1'b0;

      k = 0; cyc = 0;
      while (k < n && cyc < 400) begin
         if (gaps && (cyc % 2 == 1)) in_valid = 1'b0;
         else begin in_valid = 1'b1; input_feature = fq[k]; end
         if (disturb && cyc == 0) begin
            wr_en = 1'b1; wr_addr = AW'(5); wr_data = '1;
            start = 1'b1; n_rows = '0; base_addr = '0;
         end
         if (in_valid && in_ready_a) k++;
         tick();
         wr_en = 1'b0; start = 1'b0;
         cyc++;
      end
      in_valid = 1'b0;
      chk({nm, "_beats"}, k, n);

      lat = 0;
      while (!out_valid_a && lat < 20) begin tick(); lat++; end
      chk({nm, "_latency"}, lat, (n == 0) ? 0 : 3);
      chk({nm, "_valid_b"}, int'(out_valid_b), 1);

      xa = (sb_a.size() > 0) ? sb_a.pop_front() : -1;
      xb = (sb_b.size() > 0) ? sb_b.pop_front() : -1;
      chk({nm, "_conv16"}, int'(conv_a), xa);
      chk({nm, "_conv9"}, int'(conv_b), xb);

      for (int h = 0; h < hold; h++) begin
         tick();
         chk({nm, "_hold_valid"}, int'(out_valid_a), 1);
         chk({nm, "_hold_conv"}, int'(conv_a), xa);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({nm, "_ack_valid"}, int'(out_valid_a), 0);
      chk({nm, "_ack_busy"}, int'(busy_a), 0);
      chk({nm, "_ack_keep"}, int'(conv_a), xa);
   endtask

   initial begin
      logic [SIZE-1:0] ones, zeros, r, f8;
      ones  = '1;
      zeros = '0;
      f8    = '0;
      f8[7:0] = 8'hFF;
      for (int i = 0; i < DEPTH; i++) wmem[i] = '0;

      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      chk("rst_in_ready", int'(in_ready_a), 0);
      chk("rst_busy", int'(busy_a), 0);
      chk("rst_out_valid", int'(out_valid_a), 0);
      chk("rst_conv", int'(conv_a), 0);
      chk("rst_busy_b", int'(busy_b), 0);

      for (int i = 0; i < DEPTH; i++) wr_row(i, rnd_vec());

      wr_row(3, ones);
      fq = {f8};
      sweep("low8", 3, 1, 0, 0, 0, 0, zeros);

      wr_row(30, ones); wr_row(31, ones); wr_row(0, zeros);
      fq = {ones, ones, ones};
      sweep("wrap", 30, 3, 0, 0, 0, 0, zeros);
      sweep("bubble", 30, 3, 1, 5, 0, 0, zeros);

      wr_row(10, ones); wr_row(11, ones); wr_row(12, ones); wr_row(13, ones);
      fq = {ones, ones, ones, ones};
      sweep("satur", 10, 4, 0, 0, 0, 0, zeros);

      fq = {};
      sweep("nrows0", 7, 0, 0, 0, 0, 0, zeros);

      fq = {rnd_vec(), rnd_vec()};
      sweep("disturb", 2, 2, 0, 0, 1, 0, zeros);
      fq = {ones};
      sweep("row5_kept", 5, 1, 0, 0, 0, 0, zeros);

      r = rnd_vec();
      fq = {rnd_vec()};
      sweep("wr_start", 7, 1, 0, 0, 0, 1, r);

      r = rnd_vec();
      wr_row(20, r); wr_row(21, ~r);
      fq = {r};
      sweep("match", 20, 1, 0, 0, 0, 0, zeros);
      sweep("anti", 21, 1, 0, 0, 0, 0, zeros);

      start = 1'b1; base_addr = AW'(10); n_rows = AW'(4);
      tick();
      start = 1'b0;
      in_valid = 1'b1; input_feature = ones;
      tick(); tick();
      in_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_busy", int'(busy_a), 0);
      chk("abort_valid", int'(out_valid_a), 0);
      chk("abort_conv", int'(conv_a), 0);
      chk("abort_in_ready", int'(in_ready_a), 0);
      for (int i = 0; i < 6; i++) tick();
      chk("abort_no_result", int'(out_valid_a), 0);

      fq = {rnd_vec(), rnd_vec(), rnd_vec(), rnd_vec(), rnd_vec()};
      sweep("after_rst", 14, 5, 1, 2, 0, 0, zeros);
      fq = {ones, ones, ones, ones};
      sweep("retained", 10, 4, 0, 0, 0, 0, zeros);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
